// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: shares the single register-file write port between the in-order
// pipeline (A, priority) and a long-latency unit (B, starvation-bounded). Optional stats via WB_ARB_STATS_EN.
module riscv_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [ADDR_W-1:0] a_idx_i,
  input  logic [DATA_W-1:0] a_val_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [ADDR_W-1:0] b_idx_i,
  input  logic [DATA_W-1:0] b_val_i,
  output logic              rd_we_o,
  output logic [ADDR_W-1:0] rd_idx_o,
  output logic [DATA_W-1:0] rd_val_o,
`ifdef WB_ARB_STATS_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       kill_cnt_o,
`endif
  output logic              b_forced_o
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic {A_PRIO, B_FORCE} state_t;

  state_t            state, state_next;
  logic [3:0]        wait_cnt, wait_next;
  logic              kill;
  logic              a_xfer, b_xfer;
  logic              fwd, fwd_sel_b;
  logic [ADDR_W-1:0] fwd_idx;
  logic [DATA_W-1:0] fwd_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= A_PRIO;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    a_ready_o  = 1'b0;
    b_ready_o  = 1'b0;
    b_forced_o = 1'b0;
    kill       = 1'b0;
    fwd        = 1'b0;
    fwd_sel_b  = 1'b0;
    if (!rst) begin
      case (state)
        A_PRIO: begin
          // Same-register collision: A's newer write makes B's result dead, so retire B silently.
          kill      = a_valid_i && b_valid_i && (a_idx_i == b_idx_i) && (a_idx_i != '0);
          a_ready_o = 1'b1;
          b_ready_o = !a_valid_i || kill;
        end
        B_FORCE: begin
          b_forced_o = 1'b1;
          b_ready_o  = 1'b1;
          a_ready_o  = !b_valid_i;
        end
        default: ;
      endcase
    end
    a_xfer = a_valid_i && a_ready_o;
    b_xfer = b_valid_i && b_ready_o;
    // A wins whenever it transfers outside B_FORCE; in B_FORCE A only transfers when B is idle.
    if (a_xfer) begin
      fwd = 1'b1;
    end else if (b_xfer) begin
      fwd       = 1'b1;
      fwd_sel_b = 1'b1;
    end
  end

  assign fwd_idx = fwd_sel_b ? b_idx_i : a_idx_i;
  assign fwd_val = fwd_sel_b ? b_val_i : a_val_i;

  always_comb begin
    wait_next = wait_cnt;
    if (!b_valid_i || b_xfer)    wait_next = 4'd0;
    else if (wait_cnt < WAIT_MAX) wait_next = wait_cnt + 4'd1;
    state_next = (wait_next == WAIT_MAX) ? B_FORCE : A_PRIO;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_we_o  <= 1'b0;
      rd_idx_o <= '0;
      rd_val_o <= '0;
    end else if (fwd) begin
      rd_we_o  <= (fwd_idx != '0);
      rd_idx_o <= fwd_idx;
      rd_val_o <= fwd_val;
    end else begin
      rd_we_o  <= 1'b0;
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= 32'd0;
      kill_cnt_o  <= 32'd0;
    end else begin
      if (a_valid_i && !a_ready_o) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (kill)                    kill_cnt_o  <= kill_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed bench for riscv_wb_arbiter (MAX_WAIT=3): priority, x0 drop, starvation, kill, reset.
module tb_riscv_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_idx, b_idx, rd_idx;
  logic [31:0] a_val, b_val, rd_val;
  logic        rd_we, b_forced;
`ifdef WB_ARB_STATS_EN
  logic [31:0] stall_cnt, kill_cnt;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_idx_i(a_idx), .a_val_i(a_val),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_idx_i(b_idx), .b_val_i(b_val),
    .rd_we_o(rd_we), .rd_idx_o(rd_idx), .rd_val_o(rd_val),
`ifdef WB_ARB_STATS_EN
    .stall_cnt_o(stall_cnt), .kill_cnt_o(kill_cnt),
`endif
    .b_forced_o(b_forced)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_idx = '0; a_val = '0;
    b_valid = 1'b0; b_idx = '0; b_val = '0;
    cyc();
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_forced", b_forced, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_we", rd_we, 0);
    chk("rst_idx", rd_idx, 0);
    chk("rst_val", rd_val, 0);

    // A only
    a_valid = 1'b1; a_idx = 5; a_val = 32'h1234;
    #1;
    chk("a_only_a_ready", a_ready, 1);
    chk("a_only_b_ready", b_ready, 0);
    cyc();
    a_valid = 1'b0;
    chk("a_only_we", rd_we, 1);
    chk("a_only_idx", rd_idx, 5);
    chk("a_only_val", rd_val, 32'h1234);
    cyc();
    chk("a_only_we_off", rd_we, 0);
    chk("a_only_idx_hold", rd_idx, 5);

    // B write to x0
    b_valid = 1'b1; b_idx = 0; b_val = 32'hFFFF_FFFF;
    #1;
    chk("x0_b_ready", b_ready, 1);
    cyc();
    b_valid = 1'b0;
    chk("x0_we", rd_we, 0);
    chk("x0_val", rd_val, 32'hFFFF_FFFF);

    // Starvation: three denials then forced
    b_valid = 1'b1; b_idx = 7; b_val = 32'h77;
    a_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_idx = 5'(i); a_val = 32'(i);
      #1;
      chk("starve_forced_lo", b_forced, 0);
      chk("starve_b_ready_lo", b_ready, 0);
      cyc();
      chk("starve_a_idx", rd_idx, 32'(i));
    end
    a_idx = 4; a_val = 32'h44;
    #1;
    chk("starve_forced", b_forced, 1);
    chk("starve_a_ready", a_ready, 0);
    chk("starve_b_ready", b_ready, 1);
    cyc();
    b_valid = 1'b0;
    chk("starve_b_idx", rd_idx, 7);
    chk("starve_b_val", rd_val, 32'h77);
    chk("starve_b_we", rd_we, 1);
    #1;
    chk("starve_release", b_forced, 0);
    chk("starve_a_resume", a_ready, 1);
    cyc();
    a_valid = 1'b0;
    chk("starve_a4_idx", rd_idx, 4);
    chk("starve_a4_val", rd_val, 32'h44);

    // Kill in A_PRIO
    a_valid = 1'b1; a_idx = 9; a_val = 32'hA;
    b_valid = 1'b1; b_idx = 9; b_val = 32'hB;
    #1;
    chk("kill_a_ready", a_ready, 1);
    chk("kill_b_ready", b_ready, 1);
    cyc();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("kill_idx", rd_idx, 9);
    chk("kill_val", rd_val, 32'hA);
    cyc();
    chk("kill_single_write", rd_we, 0);
`ifdef WB_ARB_STATS_EN
    chk("kill_cnt", kill_cnt, 1);
`endif

    // Same idx while forced: B first, then A
    a_valid = 1'b1; a_idx = 1; a_val = 32'h1;
    b_valid = 1'b1; b_idx = 9; b_val = 32'hB;
    repeat (3) cyc();
    a_idx = 9; a_val = 32'hA;
    #1;
    chk("force9_forced", b_forced, 1);
    chk("force9_a_ready", a_ready, 0);
    chk("force9_b_ready", b_ready, 1);
    cyc();
    b_valid = 1'b0;
    chk("force9_b_val", rd_val, 32'hB);
    chk("force9_b_idx", rd_idx, 9);
    #1;
    chk("force9_a_ready2", a_ready, 1);
    cyc();
    a_valid = 1'b0;
    chk("force9_a_val", rd_val, 32'hA);
    chk("force9_a_we", rd_we, 1);

    // Reset while forced
    a_valid = 1'b1; a_idx = 2; a_val = 32'h22;
    b_valid = 1'b1; b_idx = 3; b_val = 32'h33;
    repeat (3) cyc();
    chk("rstmid_forced", b_forced, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_a_ready", a_ready, 0);
    chk("rstmid_b_ready", b_ready, 0);
    chk("rstmid_forced_lo", b_forced, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rstmid_we", rd_we, 0);
    chk("rstmid_after_forced", b_forced, 0);
    chk("rstmid_a_wins", a_ready, 1);
    chk("rstmid_b_denied", b_ready, 0);
    cyc();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("rstmid_a_idx", rd_idx, 2);
    chk("rstmid_a_val", rd_val, 32'h22);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
